// File: rtl/fifo_read_streamer.sv
// fifo_read_streamer
// Read-end consumer for an asynchronous FIFO, living entirely in the read
// clock domain. Words are popped from the FIFO's show-ahead read port and
// held in a registered two-entry skid buffer. They leave as a valid/ready
// stream. Every BURST_LEN-th popped word is tagged with m_last, and each
// accepted last word advances a wrapping burst counter.
//
// Ports:
//   rclk      read-domain clock, rising edge
//   rrst      synchronous active-high reset
//   en        allows new FIFO pops (buffered words always drain)
//   rempty    FIFO empty flag
//   rdata     FIFO head word, valid while rempty=0
//   rinc      FIFO pop strobe
//   m_valid   stream word valid
//   m_data    stream word (registered, from buffer head)
//   m_last    final word of a burst (registered, from buffer head)
//   m_ready   downstream accept
//   burst_cnt completed bursts, wraps modulo 2^CNT_WIDTH
//   busy      buffer non-empty or a pop in progress
//
// Handshake: a word transfers on a rising edge where m_valid & m_ready are
// both 1. While m_valid=1 and m_ready=0, m_data/m_last hold steady and
// m_valid stays high. rinc depends only on registered state and FIFO/en/rrst
// inputs, never on m_ready, so the pop path has no combinational loop
// through the downstream consumer.

module fifo_read_streamer #(
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic                  en,
  input  logic                  rempty,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  rinc,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  burst_cnt,
  output logic                  busy
);

  // Occupancy of the skid buffer doubles as the control state.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_t;

  // BURST_LEN is at most 65535, so the beat index fits in 16 bits.
  localparam logic [15:0] LAST_BEAT = 16'(BURST_LEN - 1);

  occ_t                  occ, occ_nxt;
  logic [DATA_WIDTH-1:0] e0_data, e0_data_nxt;
  logic [DATA_WIDTH-1:0] e1_data, e1_data_nxt;
  logic                  e0_last, e0_last_nxt;
  logic                  e1_last, e1_last_nxt;
  logic [15:0]           beat, beat_nxt;
  logic [CNT_WIDTH-1:0]  cnt_nxt;
  logic                  push;
  logic                  pop;
  logic                  push_last;

  assign rinc      = en & ~rempty & (occ != OCC_TWO) & ~rrst;
  assign m_valid   = (occ != OCC_EMPTY);
  assign m_data    = e0_data;
  assign m_last    = e0_last;
  assign busy      = m_valid | rinc;

  assign push      = rinc;
  assign pop       = m_valid & m_ready;
  assign push_last = (beat == LAST_BEAT);

  always_comb begin
    occ_nxt     = occ;
    e0_data_nxt = e0_data;
    e0_last_nxt = e0_last;
    e1_data_nxt = e1_data;
    e1_last_nxt = e1_last;
    beat_nxt    = beat;
    cnt_nxt     = burst_cnt;

    // Beat position advances on every pop from the FIFO, independent of
    // en pauses or an empty FIFO, so bursts are never cut short.
    if (push) begin
      beat_nxt = push_last ? 16'd0 : beat + 16'd1;
    end

    if (pop && e0_last) begin
      cnt_nxt = burst_cnt + 1'b1;
    end

    case (occ)
      OCC_EMPTY: begin
        if (push) begin
          e0_data_nxt = rdata;
          e0_last_nxt = push_last;
          occ_nxt     = OCC_ONE;
        end
      end
      OCC_ONE: begin
        if (push && pop) begin
          // Head leaves while the new word replaces it: full throughput.
          e0_data_nxt = rdata;
          e0_last_nxt = push_last;
        end else if (push) begin
          e1_data_nxt = rdata;
          e1_last_nxt = push_last;
          occ_nxt     = OCC_TWO;
        end else if (pop) begin
          occ_nxt = OCC_EMPTY;
        end
      end
      OCC_TWO: begin
        // rinc is blocked at this occupancy, so only a pop can happen.
        if (pop) begin
          e0_data_nxt = e1_data;
          e0_last_nxt = e1_last;
          occ_nxt     = OCC_ONE;
        end
      end
      default: begin
        occ_nxt = OCC_EMPTY;
      end
    endcase
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      occ       <= OCC_EMPTY;
      e0_data   <= '0;
      e0_last   <= 1'b0;
      e1_data   <= '0;
      e1_last   <= 1'b0;
      beat      <= 16'd0;
      burst_cnt <= '0;
    end else begin
      occ       <= occ_nxt;
      e0_data   <= e0_data_nxt;
      e0_last   <= e0_last_nxt;
      e1_data   <= e1_data_nxt;
      e1_last   <= e1_last_nxt;
      beat      <= beat_nxt;
      burst_cnt <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_read_streamer.sv
// Testbench for fifo_read_streamer.
// Two instances share control inputs: instance a uses BURST_LEN=4 with a
// 16-bit burst counter, instance b uses BURST_LEN=1 with a 2-bit counter
// so counter wrap is reachable. Each has its own FIFO model (a queue).
// The reference model treats the DUT as "words popped but not yet accepted"
// (a queue) plus a running pop count that decides the last tag.

module tb_fifo_read_streamer;

  logic       rclk = 1'b0;
  logic       rrst;
  logic       en;
  logic       m_ready;

  logic       rempty_a, rempty_b;
  logic [7:0] rdata_a, rdata_b;
  logic       rinc_a, rinc_b;
  logic       m_valid_a, m_valid_b;
  logic [7:0] m_data_a, m_data_b;
  logic       m_last_a, m_last_b;
  logic [15:0] burst_cnt_a;
  logic [1:0]  burst_cnt_b;
  logic       busy_a, busy_b;

  int checks = 0;
  int errors = 0;

  // Per-instance model state.
  logic [7:0] fifo_q [2][$];
  logic [8:0] exp_q  [2][$];   // {last, data} of words held in the DUT
  int         beat_m   [2];
  int         bursts_m [2];
  int         dut_pops [2];
  int         dut_hs   [2];
  int         bl   [2] = '{4, 1};
  int         cmod [2] = '{65536, 4};

  always #5 rclk = ~rclk;

  fifo_read_streamer #(.DATA_WIDTH(8), .BURST_LEN(4), .CNT_WIDTH(16)) dut_a (
    .rclk(rclk), .rrst(rrst), .en(en), .rempty(rempty_a), .rdata(rdata_a),
    .rinc(rinc_a), .m_valid(m_valid_a), .m_data(m_data_a), .m_last(m_last_a),
    .m_ready(m_ready), .burst_cnt(burst_cnt_a), .busy(busy_a)
  );

  fifo_read_streamer #(.DATA_WIDTH(8), .BURST_LEN(1), .CNT_WIDTH(2)) dut_b (
    .rclk(rclk), .rrst(rrst), .en(en), .rempty(rempty_b), .rdata(rdata_b),
    .rinc(rinc_b), .m_valid(m_valid_b), .m_data(m_data_b), .m_last(m_last_b),
    .m_ready(m_ready), .burst_cnt(burst_cnt_b), .busy(busy_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present the FIFO model heads on the show-ahead read ports.
  task automatic refresh();
    rempty_a = (fifo_q[0].size() == 0);
    rdata_a  = (fifo_q[0].size() != 0) ? fifo_q[0][0] : 8'h00;
    rempty_b = (fifo_q[1].size() == 0);
    rdata_b  = (fifo_q[1].size() != 0) ? fifo_q[1][0] : 8'h00;
  endtask

  task automatic load(input int inst, input logic [7:0] first, input int n);
    for (int k = 0; k < n; k++) fifo_q[inst].push_back(first + 8'(k));
    refresh();
  endtask

  // One clock: check outputs at the falling edge, then advance the model
  // just after the rising edge.
  task automatic tick();
    logic       ro [2];
    logic       vo [2];
    logic       lo [2];
    logic       bo [2];
    logic [7:0] dx [2];
    logic [31:0] co [2];
    logic       do_pop [2];
    logic       do_hs  [2];
    logic [8:0] head;
    logic [7:0] w;
    int         occ;
    logic       exp_rinc;

    @(negedge rclk);
    ro[0] = rinc_a;    ro[1] = rinc_b;
    vo[0] = m_valid_a; vo[1] = m_valid_b;
    lo[0] = m_last_a;  lo[1] = m_last_b;
    bo[0] = busy_a;    bo[1] = busy_b;
    dx[0] = m_data_a;  dx[1] = m_data_b;
    co[0] = {16'b0, burst_cnt_a};
    co[1] = {30'b0, burst_cnt_b};
    for (int i = 0; i < 2; i++) begin
      occ      = exp_q[i].size();
      exp_rinc = en & (fifo_q[i].size() != 0) & (occ != 2) & ~rrst;
      check($sformatf("rinc[%0d]", i), {31'b0, ro[i]}, {31'b0, exp_rinc});
      check($sformatf("m_valid[%0d]", i), {31'b0, vo[i]}, {31'b0, occ != 0});
      if (occ != 0) begin
        head = exp_q[i][0];
        check($sformatf("m_data[%0d]", i), {24'b0, dx[i]}, {24'b0, head[7:0]});
        check($sformatf("m_last[%0d]", i), {31'b0, lo[i]}, {31'b0, head[8]});
      end
      check($sformatf("burst_cnt[%0d]", i), co[i], 32'(bursts_m[i] % cmod[i]));
      check($sformatf("busy[%0d]", i), {31'b0, bo[i]}, {31'b0, (occ != 0) | exp_rinc});
      if (ro[i] === 1'b1) dut_pops[i]++;
      if (vo[i] === 1'b1 && m_ready) dut_hs[i]++;
      do_pop[i] = exp_rinc;
      do_hs[i]  = (occ != 0) & m_ready;
    end

    @(posedge rclk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (rrst) begin
        exp_q[i].delete();
        beat_m[i]   = 0;
        bursts_m[i] = 0;
      end else begin
        if (do_hs[i]) begin
          head = exp_q[i].pop_front();
          if (head[8]) bursts_m[i]++;
        end
        if (do_pop[i]) begin
          w = fifo_q[i].pop_front();
          exp_q[i].push_back({beat_m[i] == bl[i] - 1, w});
          beat_m[i] = (beat_m[i] + 1) % bl[i];
        end
      end
    end
    refresh();
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic do_reset();
    fifo_q[0].delete();
    fifo_q[1].delete();
    refresh();
    rrst = 1'b1;
    ticks(2);
    rrst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      dut_pops[i] = 0;
      dut_hs[i]   = 0;
    end
  endtask

  initial begin
    rrst = 1'b1;
    en = 1'b0;
    m_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      beat_m[i] = 0; bursts_m[i] = 0; dut_pops[i] = 0; dut_hs[i] = 0;
    end
    refresh();
    // Bring registers out of X before model comparisons begin.
    repeat (2) @(posedge rclk);
    #1;

    // Reset then idle with an empty FIFO.
    do_reset();
    check("rst_m_data", {24'b0, m_data_a}, 32'h0);
    check("rst_m_last", {31'b0, m_last_a}, 32'h0);
    en = 1'b1;
    m_ready = 1'b1;
    ticks(10);
    check("idle_pops", dut_pops[0], 0);

    // Streaming at full rate: 8 consecutive pops, 2 bursts.
    do_reset();
    load(0, 8'h11, 8);
    ticks(8);
    check("stream_pops", dut_pops[0], 8);
    ticks(3);
    check("stream_hs", dut_hs[0], 8);
    check("stream_bursts", {16'b0, burst_cnt_a}, 32'd2);

    // Backpressure: only two pops while stalled, head held stable.
    do_reset();
    m_ready = 1'b0;
    load(0, 8'h11, 8);
    ticks(6);
    check("stall_pops", dut_pops[0], 2);
    check("stall_head", {24'b0, m_data_a}, 32'h11);
    m_ready = 1'b1;
    ticks(12);
    check("stall_hs", dut_hs[0], 8);
    check("stall_bursts", {16'b0, burst_cnt_a}, 32'd2);

    // en pause after two pops: buffer drains, beat position kept.
    do_reset();
    load(0, 8'h21, 8);
    ticks(2);
    en = 1'b0;
    ticks(5);
    check("en_pops", dut_pops[0], 2);
    check("en_drained", {31'b0, m_valid_a}, 32'h0);
    en = 1'b1;
    ticks(10);
    check("en_hs", dut_hs[0], 8);
    check("en_bursts", {16'b0, burst_cnt_a}, 32'd2);

    // BURST_LEN=1: every word last; 2-bit counter wraps on the 4th.
    do_reset();
    load(1, 8'hA0, 3);
    ticks(6);
    check("bl1_bursts", {30'b0, burst_cnt_b}, 32'd3);
    load(1, 8'hA3, 1);
    ticks(3);
    check("bl1_wrap", {30'b0, burst_cnt_b}, 32'd0);

    // Reset with two words buffered mid-burst.
    do_reset();
    load(0, 8'h31, 10);
    ticks(6);
    m_ready = 1'b0;
    ticks(3);
    check("mid_bursts", {16'b0, burst_cnt_a}, 32'd1);
    check("mid_full", {31'b0, rinc_a}, 32'h0);
    rrst = 1'b1;
    tick();
    rrst = 1'b0;
    check("mid_valid", {31'b0, m_valid_a}, 32'h0);
    check("mid_cnt", {16'b0, burst_cnt_a}, 32'd0);
    check("mid_data", {24'b0, m_data_a}, 32'h0);
    load(0, 8'h3B, 5);
    m_ready = 1'b1;
    ticks(12);
    check("post_bursts", {16'b0, burst_cnt_a}, 32'd2);

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      m_ready = ($urandom_range(0, 3) != 0);
      en      = ($urandom_range(0, 7) != 0);
      rrst    = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < 2; i++) begin
        if (fifo_q[i].size() < 6 && $urandom_range(0, 1) == 1)
          fifo_q[i].push_back(8'($urandom_range(0, 255)));
      end
      refresh();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_read_streamer.md
Name: fifo_read_streamer

Overview:
Read-end consumer for the asynchronous FIFO, operating entirely in the read clock domain. It drains the FIFO through rinc/rempty/rdata and presents the words as a valid/ready stream with a registered 2-entry skid buffer. It tags every BURST_LEN-th word with m_last and counts completed bursts. The FIFO's rdata is show-ahead: it is valid whenever rempty=0 and advances on the rclk edge where rinc=1.

Parameters:
DATA_WIDTH, 8, FIFO word / stream data width
BURST_LEN, 4, words per burst; legal range 1..65535
CNT_WIDTH, 16, width of the burst counter output

Ports:
rclk  input  1  read-domain clock; all logic is on its rising edge
rrst  input  1  synchronous, active-high reset
en  input  1  allows new FIFO pops; buffered words always drain
rempty  input  1  FIFO empty flag
rdata  input  DATA_WIDTH  FIFO head word, valid when rempty=0
rinc  output  1  FIFO pop strobe
m_valid  output  1  stream word valid
m_data  output  DATA_WIDTH  stream word
m_last  output  1  final word of a burst
m_ready  input  1  downstream accept
burst_cnt  output  CNT_WIDTH  completed bursts, wraps modulo 2^CNT_WIDTH
busy  output  1  buffer non-empty or a pop is in progress

Behaviour:
- Reset (rrst=1 at a clock edge):
  - Clears occupancy, beat counter, burst_cnt, m_valid, m_data and m_last, all to 0.
  - rinc is gated low while rrst=1.
  - A reset mid-burst discards buffered words. The beat count restarts at 0.
- Storage:
  - Two entries, each holding {data, last}. Entry0 is the head.
  - occ is a 2-bit occupancy register taking values 0..2.
- Pop rule, combinational from registered state only:
  - rinc = en & ~rempty & (occ != 2) & ~rrst.
  - There is no combinational path from m_ready to rinc.
- Push: on a clock edge with rinc=1, capture rdata with last = (beat == BURST_LEN-1).
  - beat increments on every pop and wraps to 0 after BURST_LEN-1.
  - When BURST_LEN=1, every word is last.
- Stream outputs:
  - m_valid = (occ != 0).
  - m_data and m_last come from entry0 and are registered.
  - A handshake is m_valid & m_ready at a clock edge.
  - m_data and m_last stay stable while m_valid=1 and m_ready=0.
- Occupancy update per edge (push = rinc, pop = handshake):
  - occ=0, push: entry0 <= new word; occ=1.
  - occ=1, push only: entry1 <= new word; occ=2.
  - occ=1, pop only: occ=0.
  - occ=1, push and pop: entry0 <= new word; occ stays 1. This sustains full throughput.
  - occ=2, pop: entry0 <= entry1; occ=1. Push is impossible at occ=2.
- Latency:
  - If rempty falls before edge N, rinc is high during cycle N and m_valid rises after edge N, i.e. one-cycle latency.
  - Steady state with m_ready=1: one word per cycle.
- Backpressure:
  - With m_ready=0, the block pops at most 2 words, then rinc stays 0 until space frees.
  - Once m_ready returns, the stream resumes with no word lost or duplicated.
- en:
  - en=0 only blocks pops; m_valid continues to drain the buffer.
  - The beat position is preserved across en toggles, so bursts span pauses.
- burst_cnt increments on each handshake with m_last=1 and wraps to 0.
- busy = (occ != 0) | rinc.
- FIFO empty mid-burst: rinc stays 0 and the burst continues when data arrives. The block never emits a short burst.

Test Plan:
- Reset then idle, rempty=1: rinc=0, m_valid=0, burst_cnt=0, busy=0 for 10 cycles.
- FIFO holds 0x11..0x18, en=1, m_ready=1, BURST_LEN=4: rinc high for 8 consecutive cycles. m_data is 0x11..0x18 on consecutive cycles starting one cycle after the first rinc. m_last=1 on 0x14 and 0x18. burst_cnt ends at 2.
- Same data, m_ready=0 for 6 cycles then 1: exactly 2 pops, then rinc=0. m_data holds 0x11 stable. After release, all 8 words arrive in order with no gaps or duplicates.
- en dropped after 2 pops (0x21, 0x22), held low 5 cycles, then raised: 0x21 and 0x22 drain while en=0. 0x24 carries m_last=1, so the beat position is preserved.
- BURST_LEN=1, words 0xA0..0xA2: m_last=1 on every word and burst_cnt=3.
- rrst asserted with occ=2 mid-burst: next cycle m_valid=0 and burst_cnt=0. The next popped word is beat 0, and m_last falls on the 4th word after reset.
